// File: rtl/ahb_mont_master.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | ahb_mont_master: AHB-Lite initiator running one x/m/m_inv write + result read job    |
// | Revision 1.0 - initial release                                                       |
// +--------------------------------------------------------------------------------------+
module ahb_mont_master #(
  parameter int unsigned WAIT_CYCLES = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] op_x,
  input  logic [31:0] op_m,
  input  logic [31:0] op_minv,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] result,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WR0   = 4'd1;
  localparam logic [3:0] S_WR1   = 4'd2;
  localparam logic [3:0] S_WR2   = 4'd3;
  localparam logic [3:0] S_WDATA = 4'd4;
  localparam logic [3:0] S_WAIT  = 4'd5;
  localparam logic [3:0] S_RD_A  = 4'd6;
  localparam logic [3:0] S_RD_D  = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

  logic [3:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] base_q, x_q, m_q, minv_q;
  logic [31:0] result_q;
  logic        done_q, error_q;
  logic [31:0] wdata_hold_q;
  logic        resp_err;
  logic        unused_hresp_hi;

  // First cycle of a two-cycle ERROR response.
  assign resp_err        = HRESP[0] & ~HREADY;
  assign unused_hresp_hi = HRESP[1];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_WR0;
      S_WR0:   if (HREADY) state_d = S_WR1;
      S_WR1:   if (resp_err) state_d = S_ERR; else if (HREADY) state_d = S_WR2;
      S_WR2:   if (resp_err) state_d = S_ERR; else if (HREADY) state_d = S_WDATA;
      S_WDATA: begin
        if (resp_err) begin
          state_d = S_ERR;
        end else if (HREADY) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 8'd1) state_d = S_RD_A;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_RD_A:  if (HREADY) state_d = S_RD_D;
      S_RD_D:  if (resp_err) state_d = S_ERR; else if (HREADY) state_d = S_IDLE;
      S_ERR:   if (HREADY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    HTRANS = TR_IDLE;
    HADDR  = 32'd0;
    HWRITE = 1'b0;
    HWDATA = 32'd0;
    case (state_q)
      S_WR0: begin
        HTRANS = TR_NONSEQ;
        HADDR  = base_q;
        HWRITE = 1'b1;
      end
      S_WR1: begin
        HTRANS = TR_NONSEQ;
        HADDR  = base_q + 32'h4;
        HWRITE = 1'b1;
        HWDATA = x_q;
      end
      S_WR2: begin
        HTRANS = TR_NONSEQ;
        HADDR  = base_q + 32'h8;
        HWRITE = 1'b1;
        HWDATA = m_q;
      end
      S_WDATA: HWDATA = minv_q;
      S_RD_A: begin
        HTRANS = TR_NONSEQ;
        HADDR  = base_q + 32'hC;
      end
      // Keep the failing data word on the bus through the second response cycle.
      S_ERR:   HWDATA = wdata_hold_q;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      base_q       <= 32'd0;
      x_q          <= 32'd0;
      m_q          <= 32'd0;
      minv_q       <= 32'd0;
      result_q     <= 32'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      wdata_hold_q <= 32'd0;
    end else begin
      wdata_hold_q <= HWDATA;
      done_q       <= 1'b0;
      if (state_q == S_IDLE && start) begin
        base_q <= base_addr;
        x_q    <= op_x;
        m_q    <= op_m;
        minv_q <= op_minv;
      end
      if (state_q == S_RD_D && HREADY) begin
        result_q <= HRDATA;
        done_q   <= 1'b1;
        error_q  <= 1'b0;
      end else if (state_q == S_ERR && HREADY) begin
        done_q  <= 1'b1;
        error_q <= 1'b1;
      end
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign error  = error_q;
  assign result = result_q;
  assign HSIZE  = 3'b010;

endmodule
`default_nettype wire
